// File: rtl/load_store_unit_if.sv
// Request/response and data-RAM signals of the load/store unit, bundled so that
// the core side and the RAM side share one connection point.
interface load_store_unit_if #(
  parameter int ADDRESS_WIDTH = 32
) ();
  logic                     req_valid;
  logic                     req_ready;
  logic                     req_write;
  logic [2:0]               req_funct3;
  logic [ADDRESS_WIDTH-1:0] req_addr;
  logic [31:0]              req_wdata;

  logic                     rsp_valid;
  logic [31:0]              rsp_rdata;
  logic                     rsp_error;

  logic [ADDRESS_WIDTH-1:0] ram_address;
  logic                     ram_write_enable;
  logic [31:0]              ram_wdata;
  logic [31:0]              ram_rdata;

  // The load/store unit itself.
  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, ram_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_error,
           ram_address, ram_write_enable, ram_wdata
  );

  // The core plus data RAM surrounding the unit.
  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, ram_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error,
           ram_address, ram_write_enable, ram_wdata
  );
endinterface

// File: rtl/load_store_unit.sv
// RISC-V load/store unit in front of a byte-addressed RAM with a 4-byte write port;
// SB/SH are done as read-modify-write, out-of-range or illegal requests never touch RAM.
module load_store_unit #(
  parameter int                     ADDRESS_WIDTH = 32,
  parameter logic [ADDRESS_WIDTH-1:0] MEM_TOP     = 32'h0001FFFF
) (
  input  logic               clk,
  input  logic               rst,
  load_store_unit_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  state_t                   r_state;
  state_t                   w_state_next;

  logic                     r_write;
  logic [2:0]               r_funct3;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic [31:0]              r_wdata;
  logic [31:0]              r_rsp_rdata;
  logic                     r_rsp_error;

  logic [1:0]               w_size_m1;
  logic                     w_funct3_legal;
  logic [ADDRESS_WIDTH:0]   w_last_byte;
  logic                     w_range_err;
  logic                     w_req_err;
  logic                     w_accept;
  logic [31:0]              w_load_data;
  logic [31:0]              w_merged;

  logic                     w_req_ready;
  logic                     w_rsp_valid;
  logic [ADDRESS_WIDTH-1:0] w_ram_address;
  logic                     w_ram_write_enable;
  logic [31:0]              w_ram_wdata;

  // Request classification, only meaningful while IDLE.
  always_comb begin
    w_size_m1      = 2'd0;
    w_funct3_legal = 1'b0;
    case (bus.req_funct3)
      F3_B: begin
        w_size_m1      = 2'd0;
        w_funct3_legal = 1'b1;
      end
      F3_H: begin
        w_size_m1      = 2'd1;
        w_funct3_legal = 1'b1;
      end
      F3_W: begin
        w_size_m1      = 2'd3;
        w_funct3_legal = 1'b1;
      end
      F3_BU: begin
        w_size_m1      = 2'd0;
        w_funct3_legal = !bus.req_write;
      end
      F3_HU: begin
        w_size_m1      = 2'd1;
        w_funct3_legal = !bus.req_write;
      end
      default: begin
        w_size_m1      = 2'd0;
        w_funct3_legal = 1'b0;
      end
    endcase
  end

  // One extra bit so an access straddling the top of the address space cannot wrap.
  assign w_last_byte = {1'b0, bus.req_addr} + {{(ADDRESS_WIDTH-1){1'b0}}, w_size_m1};
  assign w_range_err = w_last_byte > {1'b0, MEM_TOP};
  assign w_req_err   = !w_funct3_legal || w_range_err;
  assign w_accept    = (r_state == S_IDLE) && bus.req_valid;

  always_comb begin
    w_load_data = 32'h0;
    case (r_funct3)
      F3_B:    w_load_data = {{24{bus.ram_rdata[7]}}, bus.ram_rdata[7:0]};
      F3_H:    w_load_data = {{16{bus.ram_rdata[15]}}, bus.ram_rdata[15:0]};
      F3_W:    w_load_data = bus.ram_rdata;
      F3_BU:   w_load_data = {24'h0, bus.ram_rdata[7:0]};
      F3_HU:   w_load_data = {16'h0, bus.ram_rdata[15:0]};
      default: w_load_data = 32'h0;
    endcase
  end

  // Only SB and SH reach the merge, so funct3[0] alone selects half vs byte.
  assign w_merged = r_funct3[0] ? {bus.ram_rdata[31:16], r_wdata[15:0]}
                                : {bus.ram_rdata[31:8],  r_wdata[7:0]};

  always_comb begin
    w_state_next       = r_state;
    w_req_ready        = 1'b0;
    w_rsp_valid        = 1'b0;
    w_ram_address      = '0;
    w_ram_write_enable = 1'b0;
    w_ram_wdata        = 32'h0;
    case (r_state)
      S_IDLE: begin
        w_req_ready = 1'b1;
        if (bus.req_valid) begin
          if (w_req_err) begin
            w_state_next = S_RESP;
          end else if (bus.req_write && (bus.req_funct3 == F3_W)) begin
            w_state_next = S_WRITE;
          end else begin
            w_state_next = S_READ;
          end
        end
      end
      S_READ: begin
        w_ram_address = r_addr;
        w_state_next  = r_write ? S_WRITE : S_RESP;
      end
      S_WRITE: begin
        w_ram_address      = r_addr;
        w_ram_wdata        = r_wdata;
        w_ram_write_enable = !rst;
        w_state_next       = S_RESP;
      end
      S_RESP: begin
        w_rsp_valid  = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Response registers change only on the edge that enters RESP, so they hold
  // their value between responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_write     <= 1'b0;
      r_funct3    <= 3'b000;
      r_addr      <= '0;
      r_wdata     <= 32'h0;
      r_rsp_rdata <= 32'h0;
      r_rsp_error <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_write  <= bus.req_write;
            r_funct3 <= bus.req_funct3;
            r_addr   <= bus.req_addr;
            r_wdata  <= bus.req_wdata;
            if (w_req_err) begin
              r_rsp_rdata <= 32'h0;
              r_rsp_error <= 1'b1;
            end
          end
        end
        S_READ: begin
          if (r_write) begin
            r_wdata <= w_merged;
          end else begin
            r_rsp_rdata <= w_load_data;
            r_rsp_error <= 1'b0;
          end
        end
        S_WRITE: begin
          r_rsp_rdata <= 32'h0;
          r_rsp_error <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.req_ready        = w_req_ready;
  assign bus.rsp_valid        = w_rsp_valid;
  assign bus.rsp_rdata        = r_rsp_rdata;
  assign bus.rsp_error        = r_rsp_error;
  assign bus.ram_address      = w_ram_address;
  assign bus.ram_write_enable = w_ram_write_enable;
  assign bus.ram_wdata        = w_ram_wdata;

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sits between the core's memory stage and the byte-addressed data RAM: accepts one load/store request at a time over a valid/ready handshake and drives the RAM's address, write-enable and 32-bit write-data port. It reads the RAM's combinational 32-bit read port and produces the RISC-V load result, sign- or zero-extended per funct3. The RAM always writes four bytes, so SB/SH become a two-cycle read-modify-write. Out-of-range or illegal accesses are flagged as errors and never reach the RAM.

## Interface
- ADDRESS_WIDTH, 32, width of request and RAM address
- MEM_TOP, 32'h0001FFFF, highest valid byte address of the data RAM
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request (high only in IDLE)
- req_write  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
- req_addr  in  ADDRESS_WIDTH  byte address
- req_wdata  in  32  store data (low byte/half used for SB/SH)
- rsp_valid  out  1  one-cycle pulse: request complete
- rsp_rdata  out  32  load result, 0 for stores and errors
- rsp_error  out  1  valid with rsp_valid: illegal funct3 or out of range
- ram_address  out  ADDRESS_WIDTH  to RAM address
- ram_write_enable  out  1  to RAM write enable
- ram_wdata  out  32  to RAM write data
- ram_rdata  in  32  from RAM combinational read data

## Operation
- States: IDLE, READ, WRITE, RESP.
- IDLE: req_ready=1. On req_valid, latch write, funct3, addr, wdata; classify:
  - size = 1 (000/100), 2 (001/101), 4 (010). Legal loads: 000,001,010,100,101. Legal stores: 000,001,010.
  - Error if funct3 illegal for direction or addr+size-1 > MEM_TOP (33-bit compare, no wrap). Error -> RESP with error latched, no RAM access.
  - Load or SW -> READ (load) / WRITE (SW). SB/SH -> READ.
- READ: ram_address = latched addr.
  - Load: register result, go RESP. LB {{24{d[7]}},d[7:0]}; LH {{16{d[15]}},d[15:0]}; LW d; LBU {24'b0,d[7:0]}; LHU {16'b0,d[15:0]}.
  - SB: register merged word {d[31:8], wdata[7:0]}; SH: {d[31:16], wdata[15:0]}; go WRITE.
- WRITE: ram_address = addr, ram_wdata = merged word (SB/SH) or wdata (SW), ram_write_enable=1; go RESP.
- RESP: rsp_valid=1, rsp_error as latched, rsp_rdata = load result (0 for stores/errors); req_ready=0; go IDLE.
- No misalignment restriction: RAM is byte-addressed, any address in range is legal.
- Outside their states: ram_address=0 in IDLE, ram_wdata=0 and ram_write_enable=0 outside WRITE.

## Timing
- Accept in cycle N (req_valid && req_ready). rsp_valid in: N+2 for loads and SW; N+3 for SB/SH; N+1 for errors. Next accept no earlier than the cycle after RESP.
- No response backpressure; rsp_valid high exactly one cycle; rsp_rdata/rsp_error held until next response.
- Request inputs sampled only at accept; changes afterward ignored.
- RAM write commits on the rising edge ending the WRITE cycle; READ for SB/SH precedes it, so merge sees pre-store contents.
- ram_write_enable = (state==WRITE) && !rst, so reset in WRITE suppresses the write.
- Reset (any state, any cycle): next state IDLE; rsp_valid=0, rsp_rdata=0, rsp_error=0, req_ready=1 after reset cycle, ram_* outputs 0. Request presented during reset is dropped.

## Test plan
- SW addr 0x100 data 0xDEADBEEF, then LW 0x100 -> write strobe at N+1, rsp at N+2 with rdata 0xDEADBEEF, error 0.
- After above, SB 0x101 data 0x000000AA, LW 0x100 -> 0xDEADAAEF; LB 0x101 -> 0xFFFFFFAA; LBU 0x101 -> 0x000000AA; SB rsp at N+3.
- SH 0x102 data 0x00001234, LH 0x102 -> 0x00001234; LHU of stored 0x8001 -> 0x00008001, LH -> 0xFFFF8001.
- LW 0x1FFFD, SW 0x1FFFE, funct3 011 load, funct3 100 store -> rsp_error=1 at N+1, ram_write_enable never high, rdata 0.
- LW 0x1FFFC -> legal, no error.
- Assert rst during WRITE of SW 0x200 data 0x11111111 -> no write, LW 0x200 returns prior value, all outputs 0 after reset.
